// File: rtl/ycbcr_to_rgb.sv
// YCbCr to RGB converter: 3-stage valid/ready pipeline with clamped output.
// Define YCBCR_TO_RGB_STUDIO_RANGE_EN for studio-range (16..235) input.
module ycbcr_to_rgb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [7:0] y_data_i,
    input  logic [7:0] cb_data_i,
    input  logic [7:0] cr_data_i,
    input  logic [1:0] status_i,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [7:0] r_data_o,
    output logic [7:0] g_data_o,
    output logic [7:0] b_data_o,
    output logic [1:0] status_o
);

`ifdef YCBCR_TO_RGB_STUDIO_RANGE_EN
    localparam logic signed [8:0]  YOFF = 9'sd16;
    localparam logic signed [19:0] KY   = 20'sd298;
    localparam logic signed [19:0] KRCR = 20'sd409;
    localparam logic signed [19:0] KGCB = 20'sd100;
    localparam logic signed [19:0] KGCR = 20'sd208;
    localparam logic signed [19:0] KBCB = 20'sd516;
`else
    localparam logic signed [8:0]  YOFF = 9'sd0;
    localparam logic signed [19:0] KY   = 20'sd256;
    localparam logic signed [19:0] KRCR = 20'sd359;
    localparam logic signed [19:0] KGCB = 20'sd88;
    localparam logic signed [19:0] KGCR = 20'sd183;
    localparam logic signed [19:0] KBCB = 20'sd454;
`endif
    localparam logic signed [19:0] RND = 20'sd128;

    logic en;

    logic              v1_q, v2_q, v3_q;
    logic signed [8:0] y1_q, cb1_q, cr1_q;
    logic signed [8:0] y1_d, cb1_d, cr1_d;
    logic [1:0]        st1_q, st2_q, st3_q;

    logic signed [19:0] rs2_q, gs2_q, bs2_q;
    logic signed [19:0] rs2_d, gs2_d, bs2_d;

    logic [7:0] r3_q, g3_q, b3_q;

    function automatic logic signed [19:0] sx(input logic signed [8:0] a);
        return {{11{a[8]}}, a};
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [19:0] x);
        logic signed [19:0] sh;
        sh = x >>> 8;
        if (sh < 20'sd0)
            return 8'd0;
        else if (sh > 20'sd255)
            return 8'd255;
        else
            return sh[7:0];
    endfunction

    // A stalled output holds the whole pipe; no bubble squeezing.
    assign en      = !v3_q | ready_i;
    assign ready_o = en;

    assign y1_d  = $signed({1'b0, y_data_i}) - YOFF;
    assign cb1_d = $signed({1'b0, cb_data_i}) - 9'sd128;
    assign cr1_d = $signed({1'b0, cr_data_i}) - 9'sd128;

    assign rs2_d = KY * sx(y1_q) + KRCR * sx(cr1_q) + RND;
    assign gs2_d = KY * sx(y1_q) - KGCB * sx(cb1_q)
                 - KGCR * sx(cr1_q) + RND;
    assign bs2_d = KY * sx(y1_q) + KBCB * sx(cb1_q) + RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            y1_q  <= '0;
            cb1_q <= '0;
            cr1_q <= '0;
            st1_q <= '0;
            rs2_q <= '0;
            gs2_q <= '0;
            bs2_q <= '0;
            st2_q <= '0;
            r3_q  <= '0;
            g3_q  <= '0;
            b3_q  <= '0;
            st3_q <= '0;
        end else if (en) begin
            v1_q <= valid_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (valid_i) begin
                y1_q  <= y1_d;
                cb1_q <= cb1_d;
                cr1_q <= cr1_d;
                st1_q <= status_i;
            end
            if (v1_q) begin
                rs2_q <= rs2_d;
                gs2_q <= gs2_d;
                bs2_q <= bs2_d;
                st2_q <= st1_q;
            end
            if (v2_q) begin
                r3_q  <= clamp8(rs2_q);
                g3_q  <= clamp8(gs2_q);
                b3_q  <= clamp8(bs2_q);
                st3_q <= st2_q;
            end
        end
    end

    assign valid_o  = v3_q;
    assign r_data_o = r3_q;
    assign g_data_o = g3_q;
    assign b_data_o = b3_q;
    assign status_o = st3_q;

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Self-checking bench for ycbcr_to_rgb: vector table, scoreboard,
// stall, mid-stream reset and sustained-throughput sequences.
module tb_ycbcr_to_rgb;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [1:0] st;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b1;
    logic [7:0] y_i = '0, cb_i = '0, cr_i = '0;
    logic [1:0] st_i = '0;
    logic       ready_o, valid_o;
    logic [7:0] r_o, g_o, b_o;
    logic [1:0] st_o;

    always #5 clk = ~clk;

    ycbcr_to_rgb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .y_data_i  (y_i),
        .cb_data_i (cb_i),
        .cr_data_i (cr_i),
        .status_i  (st_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .r_data_o  (r_o),
        .g_data_o  (g_o),
        .b_data_o  (b_o),
        .status_o  (st_o)
    );

    exp_t q[$];
    exp_t cur_exp;
    exp_t hold_val;
    logic hold_v = 1'b0;
    logic acc;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   first_out = -1;
    int   last_out = -1;
    vec_t tbl[6];

    function automatic logic [7:0] clamp(input int v);
        int t;
        t = v >>> 8;
        if (t < 0) return 8'd0;
        if (t > 255) return 8'd255;
        return t[7:0];
    endfunction

    function automatic exp_t model(input logic [7:0] y, input logic [7:0] cb,
                                   input logic [7:0] cr, input logic [1:0] st);
        int yy, cbp, crp, rs, gs, bs;
        exp_t e;
        cbp = int'(cb) - 128;
        crp = int'(cr) - 128;
`ifdef YCBCR_TO_RGB_STUDIO_RANGE_EN
        yy = int'(y) - 16;
        rs = 298 * yy + 409 * crp + 128;
        gs = 298 * yy - 100 * cbp - 208 * crp + 128;
        bs = 298 * yy + 516 * cbp + 128;
`else
        yy = int'(y);
        rs = 256 * yy + 359 * crp + 128;
        gs = 256 * yy - 88 * cbp - 183 * crp + 128;
        bs = 256 * yy + 454 * cbp + 128;
`endif
        e.st = st;
        e.r  = clamp(rs);
        e.g  = clamp(gs);
        e.b  = clamp(bs);
        return e;
    endfunction

    function automatic exp_t cur_out();
        exp_t a;
        a.st = st_o;
        a.r  = r_o;
        a.g  = g_o;
        a.b  = b_o;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc = valid_i && ready_o;
        if (hold_v)
            check("stall_hold", 32'(cur_out()), 32'(hold_val));
        hold_v   = valid_o && !ready_i;
        hold_val = cur_out();
        if (valid_o && ready_i) begin
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL spurious_out: got %0h, want no output",
                         32'(cur_out()));
            end else begin
                e = q.pop_front();
                check("pixel", 32'(cur_out()), 32'(e));
            end
        end
        if (acc) q.push_back(cur_exp);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] y, input logic [7:0] cb,
                         input logic [7:0] cr, input logic [1:0] st);
        valid_i = 1'b1;
        y_i = y;
        cb_i = cb;
        cr_i = cr;
        st_i = st;
        cur_exp = model(y, cb, cr, st);
    endtask

    task automatic drain(input string name);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        check(name, 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_valid"}, 32'(valid_o), 32'd0);
        check({name, "_ready"}, 32'(ready_o), 32'd1);
        check({name, "_data"}, 32'(cur_out()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef YCBCR_TO_RGB_STUDIO_RANGE_EN
        tbl[0] = '{8'd16,  8'd128, 8'd128, 2'd1, '{2'd1, 8'd0,   8'd0,   8'd0}};
        tbl[1] = '{8'd235, 8'd128, 8'd128, 2'd2, '{2'd2, 8'd255, 8'd255, 8'd255}};
        tbl[2] = '{8'd0,   8'd128, 8'd128, 2'd3, '{2'd3, 8'd0,   8'd0,   8'd0}};
        tbl[3] = '{8'd128, 8'd128, 8'd128, 2'd0, '{2'd0, 8'd130, 8'd130, 8'd130}};
        tbl[4] = '{8'd235, 8'd128, 8'd128, 2'd1, '{2'd1, 8'd255, 8'd255, 8'd255}};
        tbl[5] = '{8'd16,  8'd128, 8'd128, 2'd2, '{2'd2, 8'd0,   8'd0,   8'd0}};
`else
        tbl[0] = '{8'd128, 8'd128, 8'd128, 2'd1, '{2'd1, 8'd128, 8'd128, 8'd128}};
        tbl[1] = '{8'd255, 8'd128, 8'd255, 2'd2, '{2'd2, 8'd255, 8'd164, 8'd255}};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   2'd3, '{2'd3, 8'd0,   8'd136, 8'd0}};
        tbl[3] = '{8'd255, 8'd255, 8'd255, 2'd0, '{2'd0, 8'd255, 8'd121, 8'd255}};
        tbl[4] = '{8'd16,  8'd128, 8'd128, 2'd1, '{2'd1, 8'd16,  8'd16,  8'd16}};
        tbl[5] = '{8'd76,  8'd85,  8'd255, 2'd2, '{2'd2, 8'd254, 8'd0,   8'd0}};
`endif

        #1 rst_n = 1'b0;
        #2 check_reset_outs("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outs("post_reset");

        // Latency: result must show at valid_o three edges after acceptance.
        drive(tbl[0].y, tbl[0].cb, tbl[0].cr, tbl[0].st);
        cur_exp = tbl[0].e;
        tick();
        check("lat_accept", 32'(acc), 32'd1);
        valid_i = 1'b0;
        check("lat_c1", 32'(valid_o), 32'd0);
        tick();
        check("lat_c2", 32'(valid_o), 32'd0);
        tick();
        check("lat_c3", 32'(valid_o), 32'd1);
        drain("lat_drain");

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].y, tbl[i].cb, tbl[i].cr, tbl[i].st);
            cur_exp = tbl[i].e;
            tick();
        end
        drain("table_drain");

        // Stall sequence: ready_i low for cycles 4..6.
        begin
            int idx;
            idx = 0;
            out_cnt = 0;
            for (int k = 0; k < 40 && (idx < 8 || q.size() > 0); k++) begin
                ready_i = !(k >= 4 && k <= 6);
                if (idx < 8)
                    drive(8'(idx * 30), 8'(255 - idx * 20), 8'(idx * 33),
                          2'(idx));
                else
                    valid_i = 1'b0;
                #1;
                check("stall_ready_o", 32'(ready_o),
                      32'(!(k >= 4 && k <= 6)));
                tick();
                if (acc) idx++;
            end
            check("stall_count", 32'(out_cnt), 32'd8);
            drain("stall_drain");
        end

        // Mid-stream reset with three pixels in flight.
        for (int i = 0; i < 3; i++) begin
            drive(8'(50 + i), 8'(60 + i), 8'(70 + i), 2'(i + 1));
            tick();
        end
        valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        q.delete();
        hold_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_cnt = 0;
        for (int k = 0; k < 8; k++) tick();
        check("midrst_no_stale", 32'(out_cnt), 32'd0);

        // Sustained throughput.
        out_cnt = 0;
        first_out = -1;
        last_out = -1;
        for (int i = 0; i < 100; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
            tick();
        end
        drain("burst_drain");
        check("burst_count", 32'(out_cnt), 32'd100);
        check("burst_span", 32'(last_out - first_out), 32'd99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
